// File: rtl/uart_cfg.sv
// ============================================================================
// Module   : uart_cfg
// Brief    : Full-duplex UART with configurable data width, parity, stop bits,
//            RX parity/framing error flags and a TX busy flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cfg #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600,
    parameter int DIV       = CLK_FREQ / BAUD_RATE,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_en,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 uart_rxd,
    output logic                 uart_txd,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_ready,
    output logic                 parity_error,
    output logic                 frame_error
);

    localparam int               CNT_W       = $clog2(DIV);
    localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] C_CNT_MID   = CNT_W'(DIV / 2);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       C_DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic             C_STOP_LAST = 1'(STOP_BITS - 1);
    localparam bit               C_HAS_PAR   = (PARITY != 0);
    localparam bit               C_ODD       = (PARITY == 2);

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_PAR   = 3'd3,
        TX_STOP  = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_PAR   = 3'd3,
        RX_STOP  = 3'd4,
        RX_BREAK = 3'd5
    } rx_state_t;

    // ------------------------------------------------------------------ TX
    tx_state_t              tx_state_q, tx_state_d;
    logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d;
    logic [2:0]             tx_idx_q, tx_idx_d;
    logic                   tx_stop_q, tx_stop_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic                   tx_par_q, tx_par_d;
    logic                   w_tx_bit_end;
    logic                   w_tx_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_stop_q  <= tx_stop_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
        end
    end

    // Busy drops in the final stop cycle so a new request there starts the next frame with no gap.
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        tx_idx_d     = tx_idx_q;
        tx_stop_d    = tx_stop_q;
        tx_shift_d   = tx_shift_q;
        tx_par_d     = tx_par_q;
        w_tx_bit_end = (tx_cnt_q == C_CNT_LAST);
        w_tx_last    = (tx_state_q == TX_STOP) && w_tx_bit_end && (tx_stop_q == C_STOP_LAST);
        tx_done      = w_tx_last;
        tx_busy      = (tx_state_q != TX_IDLE) && !w_tx_last;
        uart_txd     = 1'b1;

        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = w_tx_bit_end ? '0 : tx_cnt_q + C_CNT_ONE;
        end

        case (tx_state_q)
            TX_IDLE: ;
            TX_START: begin
                uart_txd = 1'b0;
                if (w_tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_idx_d   = '0;
                end
            end
            TX_DATA: begin
                uart_txd = tx_shift_q[0];
                if (w_tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_idx_q == C_DATA_LAST) begin
                        tx_state_d = C_HAS_PAR ? TX_PAR : TX_STOP;
                        tx_stop_d  = 1'b0;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                    end
                end
            end
            TX_PAR: begin
                uart_txd = tx_par_q;
                if (w_tx_bit_end) begin
                    tx_state_d = TX_STOP;
                    tx_stop_d  = 1'b0;
                end
            end
            TX_STOP: begin
                if (w_tx_bit_end) begin
                    if (tx_stop_q == C_STOP_LAST) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_stop_d = tx_stop_q + 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        if (tx_en && !tx_busy) begin
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_shift_d = tx_data;
            tx_par_d   = C_ODD ? ~^tx_data : ^tx_data;
        end
    end

    // ------------------------------------------------------------------ RX
    logic                   rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_t              rx_state_q, rx_state_d;
    logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
    logic [2:0]             rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic                   rx_perr_q, rx_perr_d;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   rx_pe_q, rx_fe_q;
    logic                   w_rx_line;
    logic                   w_rx_mid;
    logic                   w_rx_ready;
    logic                   w_rx_pe_new;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_pe_q    <= 1'b0;
            rx_fe_q    <= 1'b0;
        end else begin
            rx_s1_q    <= uart_rxd;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
            if (w_rx_ready) begin
                rx_data_q <= rx_shift_q;
                rx_pe_q   <= w_rx_pe_new;
                rx_fe_q   <= ~w_rx_line;
            end
        end
    end

    // The falling edge is seen in cycle E with the counter at 0, so the midpoint lands at E + DIV/2.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_idx_d    = rx_idx_q;
        rx_shift_d  = rx_shift_q;
        rx_perr_d   = rx_perr_q;
        w_rx_line   = rx_s2_q;
        w_rx_mid    = (rx_cnt_q == C_CNT_MID);
        w_rx_ready  = (rx_state_q == RX_STOP) && w_rx_mid;
        w_rx_pe_new = C_HAS_PAR && rx_perr_q;

        if (rx_cnt_q == C_CNT_LAST) begin
            rx_cnt_d = '0;
        end else begin
            rx_cnt_d = rx_cnt_q + C_CNT_ONE;
        end

        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_s3_q && !w_rx_line) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = C_CNT_ONE;
                end
            end
            RX_START: begin
                if (w_rx_mid) begin
                    rx_state_d = w_rx_line ? RX_IDLE : RX_DATA;
                    rx_idx_d   = '0;
                end
            end
            RX_DATA: begin
                if (w_rx_mid) begin
                    rx_shift_d = {w_rx_line, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_idx_q == C_DATA_LAST) begin
                        rx_state_d = C_HAS_PAR ? RX_PAR : RX_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end
            end
            RX_PAR: begin
                if (w_rx_mid) begin
                    rx_perr_d  = w_rx_line != (C_ODD ? ~^rx_shift_q : ^rx_shift_q);
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_rx_mid) begin
                    rx_state_d = w_rx_line ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK: begin
                rx_cnt_d = '0;
                if (w_rx_line) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        rx_ready     = w_rx_ready;
        rx_data      = w_rx_ready ? rx_shift_q  : rx_data_q;
        parity_error = w_rx_ready ? w_rx_pe_new : rx_pe_q;
        frame_error  = w_rx_ready ? ~w_rx_line  : rx_fe_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_cfg.sv
// ============================================================================
// Module   : tb_uart_cfg
// Brief    : Self-checking bench for uart_cfg (8N1 TX/RX, 7E2 loopback, 8O1 RX).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_cfg;

    localparam int DIV = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: 8N1
    logic       tx_en_a, rxd_a;
    logic [7:0] tx_data_a, rxdata_a;
    logic       txd_a, busy_a, done_a, rdy_a, pe_a, fe_a;
    // DUT B: 7E2, loopback
    logic       tx_en_b;
    logic [6:0] tx_data_b, rxdata_b;
    logic       txd_b, busy_b, done_b, rdy_b, pe_b, fe_b;
    // DUT C: 8O1, RX only
    logic       tx_en_c, rxd_c;
    logic [7:0] tx_data_c, rxdata_c;
    logic       txd_c, busy_c, done_c, rdy_c, pe_c, fe_c;

    uart_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en_a), .tx_data(tx_data_a), .uart_rxd(rxd_a),
        .uart_txd(txd_a), .tx_busy(busy_a), .tx_done(done_a), .rx_data(rxdata_a),
        .rx_ready(rdy_a), .parity_error(pe_a), .frame_error(fe_a));

    uart_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en_b), .tx_data(tx_data_b), .uart_rxd(txd_b),
        .uart_txd(txd_b), .tx_busy(busy_b), .tx_done(done_b), .rx_data(rxdata_b),
        .rx_ready(rdy_b), .parity_error(pe_b), .frame_error(fe_b));

    uart_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en_c), .tx_data(tx_data_c), .uart_rxd(rxd_c),
        .uart_txd(txd_c), .tx_busy(busy_c), .tx_done(done_c), .rx_data(rxdata_c),
        .rx_ready(rdy_c), .parity_error(pe_c), .frame_error(fe_c));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: parity and frame bits from the format rules.
    function automatic logic model_parity(input logic [7:0] d, input int db, input int mode);
        int ones = 0;
        for (int i = 0; i < db; i++) ones += int'(d[i]);
        return (mode == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
    endfunction

    function automatic logic model_bit(input int idx, input logic [7:0] d, input int db, input int mode);
        if (idx == 0) return 1'b0;
        if (idx <= db) return d[idx-1];
        if (mode != 0 && idx == db + 1) return model_parity(d, db, mode);
        return 1'b1;
    endfunction

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         cyc;
    } rx_ev_t;

    rx_ev_t q_a[$];
    rx_ev_t q_b[$];
    rx_ev_t q_c[$];
    int     done_cnt_a = 0;

    always @(negedge clk) begin : mon
        rx_ev_t e;
        if (rdy_a) begin e.d = rxdata_a;         e.pe = pe_a; e.fe = fe_a; e.cyc = cyc; q_a.push_back(e); end
        if (rdy_b) begin e.d = {1'b0, rxdata_b}; e.pe = pe_b; e.fe = fe_b; e.cyc = cyc; q_b.push_back(e); end
        if (rdy_c) begin e.d = rxdata_c;         e.pe = pe_c; e.fe = fe_c; e.cyc = cyc; q_c.push_back(e); end
        if (done_a) done_cnt_a++;
    end

    task automatic set_line(input bit to_c, input logic v);
        if (to_c) rxd_c = v;
        else      rxd_a = v;
    endtask

    // Drives start, 8 data bits, optional parity bit (pbit < 0 means none) and one stop bit.
    task automatic drive_frame(input bit to_c, input logic [7:0] d, input int pbit, input logic stop, output int t0);
        logic [10:0] fb;
        int          n;
        fb = '0;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = d[i];
        n = 9;
        if (pbit >= 0) begin
            fb[9] = pbit[0];
            n = 10;
        end
        fb[n] = stop;
        n = n + 1;
        @(posedge clk); #1;
        t0 = cyc;
        for (int i = 0; i < n; i++) begin
            set_line(to_c, fb[i]);
            repeat (DIV) @(posedge clk);
            #1;
        end
    endtask

    task automatic rx_expect(input int which, input string tag, input logic [7:0] d,
                             input logic pe, input logic fe, input int tcyc);
        rx_ev_t e;
        int     n;
        case (which)
            0:       n = q_a.size();
            1:       n = q_b.size();
            default: n = q_c.size();
        endcase
        chk({tag, "_count"}, n, 1);
        if (n > 0) begin
            case (which)
                0:       e = q_a.pop_front();
                1:       e = q_b.pop_front();
                default: e = q_c.pop_front();
            endcase
            chk({tag, "_data"}, e.d, d);
            chk({tag, "_perr"}, e.pe, pe);
            chk({tag, "_ferr"}, e.fe, fe);
            chk({tag, "_cycle"}, e.cyc, tcyc);
        end
        q_a.delete();
        q_b.delete();
        q_c.delete();
    endtask

    // Called during the request cycle N with tx_en_a already high; checks every cycle N+1..N+F.
    task automatic tx_run_a(input logic [7:0] d, input bit chain, input logic [7:0] d_next, input bit poke);
        int f;
        f = 10 * DIV;
        @(posedge clk); #1;
        tx_en_a   = 1'b0;
        tx_data_a = 8'($urandom);
        for (int k = 1; k <= f; k++) begin
            @(negedge clk);
            chk("a_txd", txd_a, model_bit((k - 1) / DIV, d, 8, 0));
            chk("a_busy", busy_a, (k < f));
            chk("a_done", done_a, (k == f));
            if (poke && k == f / 2) begin tx_en_a = 1'b1; tx_data_a = ~d; end
            if (poke && k == f / 2 + 1) tx_en_a = 1'b0;
            if (chain && k == f) begin tx_en_a = 1'b1; tx_data_a = d_next; end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int         t0, tn, k, dcnt;
        logic [7:0] d, d2, pb;

        rst_n = 1'b0;
        tx_en_a = 1'b0; tx_data_a = '0; rxd_a = 1'b1;
        tx_en_b = 1'b0; tx_data_b = '0;
        tx_en_c = 1'b0; tx_data_c = '0; rxd_c = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_txd_a", txd_a, 1);
        chk("rst_txd_b", txd_b, 1);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_ready_a", rdy_a, 0);
        chk("rst_rxdata_a", rxdata_a, 0);
        chk("rst_perr_c", pe_c, 0);
        chk("rst_ferr_a", fe_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // TX 8N1: fixed 0xA5, then a frame poked mid-flight and chained back-to-back.
        #1; tx_en_a = 1'b1; tx_data_a = 8'hA5;
        tx_run_a(8'hA5, 1'b0, 8'h00, 1'b0);
        @(posedge clk); #1;
        d = 8'($urandom); d2 = 8'($urandom);
        tx_en_a = 1'b1; tx_data_a = d;
        tx_run_a(d, 1'b1, d2, 1'b1);
        tx_run_a(d2, 1'b0, 8'h00, 1'b0);

        // Mid-frame reset.
        @(posedge clk); #1;
        tx_en_a = 1'b1; tx_data_a = 8'h00;
        @(posedge clk); #1;
        tx_en_a = 1'b0;
        repeat (40) @(posedge clk);
        #1; rst_n = 1'b0;
        dcnt = done_cnt_a;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_txd", txd_a, 1);
        chk("midrst_busy", busy_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (120) @(posedge clk);
        chk("midrst_no_done", done_cnt_a, dcnt);

        // 7E2 loopback.
        for (int i = 0; i < 5; i++) begin
            d = (i == 0) ? 8'h55 : 8'($urandom_range(0, 127));
            @(posedge clk); #1;
            tx_en_b = 1'b1; tx_data_b = d[6:0]; tn = cyc;
            @(posedge clk); #1;
            tx_en_b = 1'b0;
            for (k = 1; k <= 200; k++) begin
                @(negedge clk);
                if (k == 85) chk("b_par_bit", txd_b, model_bit(8, d, 7, 1));
                if (done_b) break;
            end
            chk("b_done_at", cyc - tn, 110);
            rx_expect(1, "b_rx", d, 1'b0, 1'b0, tn + 98);
        end

        // 8O1 RX: wrong parity, then correct and random parity bits.
        drive_frame(1'b1, 8'h0F, 0, 1'b1, t0);
        rx_expect(2, "c_badpar", 8'h0F, 1'b1, 1'b0, t0 + 107);
        for (int i = 0; i < 4; i++) begin
            d  = 8'($urandom);
            pb = (i == 0) ? {7'd0, model_parity(d, 8, 2)} : 8'($urandom_range(0, 1));
            drive_frame(1'b1, d, int'(pb), 1'b1, t0);
            rx_expect(2, "c_rx", d, pb[0] != model_parity(d, 8, 2), 1'b0, t0 + 107);
        end

        // 8N1 RX: random frames, glitch, break.
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            drive_frame(1'b0, d, -1, 1'b1, t0);
            rx_expect(0, "a_rx", d, 1'b0, 1'b0, t0 + 97);
        end
        @(posedge clk); #1;
        rxd_a = 1'b0;
        repeat (3) @(posedge clk);
        #1; rxd_a = 1'b1;
        repeat (3 * DIV) @(posedge clk);
        chk("a_glitch_count", q_a.size(), 0);
        drive_frame(1'b0, 8'h3C, -1, 1'b1, t0);
        rx_expect(0, "a_after_glitch", 8'h3C, 1'b0, 1'b0, t0 + 97);

        d = 8'($urandom);
        drive_frame(1'b0, d, -1, 1'b0, t0);
        repeat (30 * DIV) @(posedge clk);
        #1;
        rx_expect(0, "a_break", d, 1'b0, 1'b1, t0 + 97);
        rxd_a = 1'b1;
        repeat (3 * DIV) @(posedge clk);
        #1;
        chk("a_break_quiet", q_a.size(), 0);
        d = 8'($urandom);
        drive_frame(1'b0, d, -1, 1'b1, t0);
        rx_expect(0, "a_after_break", d, 1'b0, 1'b0, t0 + 97);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
